// File: rtl/fighter_pkg.sv
// Shared fighter definitions: action-state encodings and default animation frame counts.
package fighter_pkg;

    // Encodings are consumed directly by the sprite modules and the game FSM.
    typedef enum logic [7:0] {
        StStand  = 8'd0,
        StAttack = 8'd1,
        StMoveL  = 8'd2,
        StMoveR  = 8'd3,
        StHurt   = 8'd4,
        StDefend = 8'd5,
        StDie    = 8'd6
    } char_state_t;

    localparam int unsigned DefFrameHold = 4;
    localparam int unsigned DefNStand    = 8;
    localparam int unsigned DefNMove     = 5;
    localparam int unsigned DefNAttack   = 9;
    localparam int unsigned DefNHurt     = 4;
    localparam int unsigned DefNDefend   = 1;
    localparam int unsigned DefNDie      = 12;
    localparam int unsigned DefHitFirst  = 3;
    localparam int unsigned DefHitLast   = 5;

endpackage

// File: rtl/frame_tick.sv
// Brings the asynchronous frame strobe into the system clock domain and emits a
// one-cycle tick per rising edge (two synchronizer stages plus one edge flop).
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic tick
);

    logic sync1, sync2, sync3;

    // Synchronizer chain and registered rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            sync3 <= sync2;
            tick  <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter action arbiter and animation sequencer. All state decisions happen on
// the synchronized frame tick; hits between ticks are remembered in a pending flag.
module fighter_anim_ctrl
    import fighter_pkg::*;
#(
    parameter int unsigned FRAME_HOLD = DefFrameHold,
    parameter int unsigned N_STAND    = DefNStand,
    parameter int unsigned N_MOVE     = DefNMove,
    parameter int unsigned N_ATTACK   = DefNAttack,
    parameter int unsigned N_HURT     = DefNHurt,
    parameter int unsigned N_DEFEND   = DefNDefend,
    parameter int unsigned N_DIE      = DefNDie,
    parameter int unsigned HIT_FIRST  = DefHitFirst,
    parameter int unsigned HIT_LAST   = DefHitLast
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       key_defend,
    input  logic       hit_in,
    input  logic       hp_zero,
    output logic [7:0] character_state,
    output logic [7:0] frame_num,
    output logic       move_l,
    output logic       move_r,
    output logic       attack_active,
    output logic       blocked,
    output logic       die_done
);

    localparam int unsigned HoldW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    char_state_t      state_q, state_d;
    char_state_t      key_state, target;
    logic [7:0]       frame_q, frame_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             pending_q, pending_d;
    logic             die_done_q, die_done_d;
    logic             move_l_q, move_l_d;
    logic             move_r_q, move_r_d;
    logic             tick, hit_seen, hit_now, hold_wrap, last_frame, enter;

    frame_tick u_frame_tick (
        .clk   (Clk),
        .rst   (Reset),
        .level (frame_clk),
        .tick  (tick)
    );

    function automatic logic [7:0] frame_count(input char_state_t s);
        case (s)
            StAttack: frame_count = 8'(N_ATTACK);
            StMoveL:  frame_count = 8'(N_MOVE);
            StMoveR:  frame_count = 8'(N_MOVE);
            StHurt:   frame_count = 8'(N_HURT);
            StDefend: frame_count = 8'(N_DEFEND);
            StDie:    frame_count = 8'(N_DIE);
            default:  frame_count = 8'(N_STAND);
        endcase
    endfunction

    // A hit during defend is absorbed (reported as blocked) and never becomes pending.
    assign hit_seen   = hit_in && (state_q != StDefend);
    assign hit_now    = pending_q || hit_seen;
    assign hold_wrap  = (hold_q == HoldW'(FRAME_HOLD - 1));
    assign last_frame = (frame_q == frame_count(state_q) - 8'd1);

    // Player-requested action; both directions together cancel to stand.
    always_comb begin
        if (key_defend) begin
            key_state = StDefend;
        end else if (key_attack) begin
            key_state = StAttack;
        end else if (key_right && !key_left) begin
            key_state = StMoveR;
        end else if (key_left && !key_right) begin
            key_state = StMoveL;
        end else begin
            key_state = StStand;
        end
    end

    // Next-state: priority arbitration on tick, then hold/frame counter advance.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        hold_d     = hold_q;
        pending_d  = pending_q | hit_seen;
        die_done_d = die_done_q;
        move_l_d   = 1'b0;
        move_r_d   = 1'b0;
        enter      = 1'b0;
        target     = key_state;

        if (!enable) begin
            state_d    = StStand;
            frame_d    = 8'd0;
            hold_d     = '0;
            pending_d  = 1'b0;
            die_done_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b0;
            if (hp_zero && state_q != StDie) begin
                enter  = 1'b1;
                target = StDie;
            end else if (hit_now && state_q != StDefend && state_q != StDie) begin
                enter  = 1'b1;
                target = StHurt;
            end else if (state_q == StAttack || state_q == StHurt) begin
                // One-shot animations re-arbitrate only once their last frame completes.
                enter = hold_wrap && last_frame;
            end else if (state_q != StDie) begin
                enter = (key_state != state_q);
            end

            if (enter) begin
                state_d = target;
                frame_d = 8'd0;
                hold_d  = '0;
            end else begin
                hold_d = hold_wrap ? '0 : hold_q + HoldW'(1);
                if (hold_wrap) begin
                    if (!last_frame) begin
                        frame_d = frame_q + 8'd1;
                    end else if (state_q != StDie) begin
                        frame_d = 8'd0;
                    end
                end
                // Done as soon as the final die frame is shown.
                if (state_q == StDie && hold_wrap && (frame_q + 8'd2 >= 8'(N_DIE))) begin
                    die_done_d = 1'b1;
                end
                move_l_d = (state_q == StMoveL);
                move_r_d = (state_q == StMoveR);
            end
        end
    end

    // State, counters and registered strobes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StStand;
            frame_q    <= 8'd0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            die_done_q <= 1'b0;
            move_l_q   <= 1'b0;
            move_r_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            die_done_q <= die_done_d;
            move_l_q   <= move_l_d;
            move_r_q   <= move_r_d;
        end
    end

    assign character_state = state_q;
    assign frame_num       = frame_q;
    assign move_l          = move_l_q;
    assign move_r          = move_r_q;
    assign die_done        = die_done_q;
    assign blocked         = enable && hit_in && (state_q == StDefend);
    assign attack_active   = (state_q == StAttack) && (frame_q >= 8'(HIT_FIRST))
                             && (frame_q <= 8'(HIT_LAST));

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Self-checking bench for fighter_anim_ctrl: a table of tick-level vectors plus a few
// hand-written sequences for hits, blocking, death, soft restart and reset.
module tb_fighter_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       enable = 1'b1;
    logic       key_left = 1'b0, key_right = 1'b0, key_attack = 1'b0, key_defend = 1'b0;
    logic       hit_in = 1'b0;
    logic       hp_zero = 1'b0;
    logic [7:0] character_state, frame_num;
    logic       move_l, move_r, attack_active, blocked, die_done;

    typedef struct packed {
        logic [7:0] st;
        logic [7:0] fr;
        logic       act;
        logic       dd;
        logic [7:0] ml;
        logic [7:0] mr;
    } exp_t;

    typedef struct {
        logic [3:0] keys;  // {left, right, attack, defend}
        int         ticks;
        logic [7:0] st;
        logic [7:0] fr;
        logic       act;
        int         ml;
        int         mr;
    } vec_t;

    localparam logic [3:0] K0 = 4'b0000, KL = 4'b1000, KR = 4'b0100;
    localparam logic [3:0] KA = 4'b0010, KD = 4'b0001;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   ml_cnt = 0;
    int   mr_cnt = 0;

    fighter_anim_ctrl dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_clk       (frame_clk),
        .enable          (enable),
        .key_left        (key_left),
        .key_right       (key_right),
        .key_attack      (key_attack),
        .key_defend      (key_defend),
        .hit_in          (hit_in),
        .hp_zero         (hp_zero),
        .character_state (character_state),
        .frame_num       (frame_num),
        .move_l          (move_l),
        .move_r          (move_r),
        .attack_active   (attack_active),
        .blocked         (blocked),
        .die_done        (die_done)
    );

    always #10 Clk = ~Clk;

    // Count one-cycle movement strobes.
    always @(negedge Clk) begin
        if (move_l) ml_cnt = ml_cnt + 1;
        if (move_r) mr_cnt = mr_cnt + 1;
    end

    // One frame_clk pulse; the tick is live in the 4th Clk, optionally with hit_in alongside.
    task automatic do_tick(input bit hit_at);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        if (hit_at) hit_in = 1'b1;
        @(negedge Clk);
        hit_in    = 1'b0;
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic hit_pulse();
        @(negedge Clk);
        hit_in = 1'b1;
        @(negedge Clk);
        hit_in = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic drive_and_check(input string tag, input logic [3:0] keys, input bit hit_at,
                                   input int nt, input logic [7:0] st, input logic [7:0] fr,
                                   input logic act, input logic dd, input int ml, input int mr);
        exp_t e, got;
        int   ml0, mr0;
        {key_left, key_right, key_attack, key_defend} = keys;
        e.st  = st;
        e.fr  = fr;
        e.act = act;
        e.dd  = dd;
        e.ml  = 8'(ml);
        e.mr  = 8'(mr);
        exp_q.push_back(e);
        ml0 = ml_cnt;
        mr0 = mr_cnt;
        for (int i = 0; i < nt; i++) do_tick(hit_at && (i == 0));
        got.st  = character_state;
        got.fr  = frame_num;
        got.act = attack_active;
        got.dd  = die_done;
        got.ml  = 8'(ml_cnt - ml0);
        got.mr  = 8'(mr_cnt - mr0);
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d fr=%0d act=%0b dd=%0b ml=%0d mr=%0d, expected st=%0d fr=%0d act=%0b dd=%0b ml=%0d mr=%0d",
                     tag, got.st, got.fr, got.act, got.dd, got.ml, got.mr,
                     e.st, e.fr, e.act, e.dd, e.ml, e.mr);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // keys, ticks, state, frame, attack_active, move_l pulses, move_r pulses
        tbl.push_back(vec_t'{K0,       0, 8'd0, 8'd0, 1'b0, 0, 0});   // reset state
        tbl.push_back(vec_t'{K0,      40, 8'd0, 8'd2, 1'b0, 0, 0});   // stand loops 0..7
        tbl.push_back(vec_t'{K0,       3, 8'd0, 8'd2, 1'b0, 0, 0});
        tbl.push_back(vec_t'{K0,       1, 8'd0, 8'd3, 1'b0, 0, 0});
        tbl.push_back(vec_t'{KR,       1, 8'd3, 8'd0, 1'b0, 0, 0});   // entry: no strobe
        tbl.push_back(vec_t'{KR,       7, 8'd3, 8'd1, 1'b0, 0, 7});
        tbl.push_back(vec_t'{KR,      13, 8'd3, 8'd0, 1'b0, 0, 13});  // frame wraps 4 -> 0
        tbl.push_back(vec_t'{KL | KR,  1, 8'd0, 8'd0, 1'b0, 0, 0});   // both keys: stand
        tbl.push_back(vec_t'{KL,       1, 8'd2, 8'd0, 1'b0, 0, 0});
        tbl.push_back(vec_t'{KL,       4, 8'd2, 8'd1, 1'b0, 4, 0});
        tbl.push_back(vec_t'{K0,       1, 8'd0, 8'd0, 1'b0, 0, 0});
        tbl.push_back(vec_t'{KA,       1, 8'd1, 8'd0, 1'b0, 0, 0});   // attack, 36 ticks
        tbl.push_back(vec_t'{K0,      11, 8'd1, 8'd2, 1'b0, 0, 0});
        tbl.push_back(vec_t'{K0,       1, 8'd1, 8'd3, 1'b1, 0, 0});   // window opens
        tbl.push_back(vec_t'{K0,      11, 8'd1, 8'd5, 1'b1, 0, 0});
        tbl.push_back(vec_t'{K0,       1, 8'd1, 8'd6, 1'b0, 0, 0});   // window closed
        tbl.push_back(vec_t'{K0,      11, 8'd1, 8'd8, 1'b0, 0, 0});
        tbl.push_back(vec_t'{K0,       1, 8'd0, 8'd0, 1'b0, 0, 0});   // back to stand
        tbl.push_back(vec_t'{KA,       1, 8'd1, 8'd0, 1'b0, 0, 0});
        tbl.push_back(vec_t'{KL | KD,  5, 8'd1, 8'd1, 1'b0, 0, 0});   // locked in attack
        tbl.push_back(vec_t'{KD,      31, 8'd5, 8'd0, 1'b0, 0, 0});   // then defend
        tbl.push_back(vec_t'{KD,       3, 8'd5, 8'd0, 1'b0, 0, 0});

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        foreach (tbl[i]) begin
            drive_and_check($sformatf("vec%0d", i), tbl[i].keys, 1'b0, tbl[i].ticks,
                            tbl[i].st, tbl[i].fr, tbl[i].act, 1'b0, tbl[i].ml, tbl[i].mr);
        end

        // Hit while defending: blocked in the same Clk, no pending hurt afterwards.
        @(negedge Clk);
        hit_in = 1'b1;
        #1 chk("blocked_on", 32'(blocked), 32'd1);
        @(negedge Clk);
        hit_in = 1'b0;
        #1 chk("blocked_off", 32'(blocked), 32'd0);
        drive_and_check("defend_holds", KD, 1'b0, 1, 8'd5, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_and_check("no_pending", K0, 1'b0, 1, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);

        // Hit during attack frame 2 interrupts into hurt for 16 ticks.
        drive_and_check("atk_start", KA, 1'b0, 1, 8'd1, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_and_check("atk_f2", K0, 1'b0, 8, 8'd1, 8'd2, 1'b0, 1'b0, 0, 0);
        hit_pulse();
        drive_and_check("hurt_entry", K0, 1'b0, 1, 8'd4, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_and_check("hurt_last", K0, 1'b0, 15, 8'd4, 8'd3, 1'b0, 1'b0, 0, 0);
        drive_and_check("hurt_done", K0, 1'b0, 1, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_and_check("pend_clear", K0, 1'b0, 1, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);

        // hit_in coinciding with the tick is acted on at that tick.
        drive_and_check("hit_at_tick", K0, 1'b1, 1, 8'd4, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_and_check("hurt2_done", K0, 1'b0, 16, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);

        // hp_zero beats a pending hit; die runs to frame 11 and holds.
        hit_pulse();
        hp_zero = 1'b1;
        drive_and_check("die_entry", K0, 1'b0, 1, 8'd6, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_and_check("die_f10", K0, 1'b0, 43, 8'd6, 8'd10, 1'b0, 1'b0, 0, 0);
        drive_and_check("die_f11", K0, 1'b0, 1, 8'd6, 8'd11, 1'b0, 1'b1, 0, 0);
        hit_pulse();
        drive_and_check("die_hold", KR, 1'b0, 10, 8'd6, 8'd11, 1'b0, 1'b1, 0, 0);

        // One Clk of enable low is a soft restart.
        @(negedge Clk);
        enable    = 1'b0;
        hp_zero   = 1'b0;
        key_right = 1'b0;
        @(negedge Clk);
        enable = 1'b1;
        chk("restart_state", 32'(character_state), 32'd0);
        chk("restart_frame", 32'(frame_num), 32'd0);
        chk("restart_done", 32'(die_done), 32'd0);

        // Ticks are ignored while enable is low.
        enable = 1'b0;
        drive_and_check("disabled_tick", KR, 1'b0, 1, 8'd0, 8'd0, 1'b0, 1'b0, 0, 0);
        enable = 1'b1;

        // Reset mid-animation.
        drive_and_check("rst_atk", KA, 1'b0, 1, 8'd1, 8'd0, 1'b0, 1'b0, 0, 0);
        drive_and_check("rst_atk_f1", K0, 1'b0, 5, 8'd1, 8'd1, 1'b0, 1'b0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("reset_state", 32'(character_state), 32'd0);
        chk("reset_frame", 32'(frame_num), 32'd0);
        repeat (6) @(negedge Clk);
        chk("reset_no_tick", 32'(frame_num), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
